// File: rtl/device_event_encoder_pkg.sv
// -----------------------------------------------------------------------------
// device_event_encoder_pkg
// Shared definitions for the active-device event link (encoder and monitor).
//   CNT_W          : width of the active-device count
//   EVT_ON/EVT_OFF : event direction encoding carried on on_off
//   N_DEV_DEFAULT  : default number of monitored devices
//   ID_W_DEFAULT   : default device index width
//   cnt_step()     : apply one event to a count value
// -----------------------------------------------------------------------------
package device_event_encoder_pkg;

  localparam int   CNT_W         = 8;
  localparam logic EVT_ON        = 1'b1;
  localparam logic EVT_OFF       = 1'b0;
  localparam int   N_DEV_DEFAULT = 8;
  localparam int   ID_W_DEFAULT  = 3;

  // Count after one issued event: increment for on, decrement for off.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic             dir);
    logic [CNT_W-1:0] res;
    if (dir == EVT_ON) begin
      res = cnt + CNT_W'(1);
    end else begin
      res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/device_event_encoder_if.sv
// -----------------------------------------------------------------------------
// device_event_encoder_if
// Bundle of the device-status inputs and the event link outputs.
//   dev_status : per-device on/off level
//   stall      : hold events this cycle
//   change     : one-cycle event strobe
//   on_off     : event direction (1 = on / increment)
//   dev_id     : device index of the event
//   pending    : at least one event buffered
//   active_cnt : shadow of the downstream active-device counter
// Modports: master = encoder side, slave = source/consumer side.
// -----------------------------------------------------------------------------
interface device_event_encoder_if #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3
) ();
  import device_event_encoder_pkg::*;

  logic [N_DEV-1:0] dev_status;
  logic             stall;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic             pending;
  logic [CNT_W-1:0] active_cnt;

  modport master (
    input  dev_status, stall,
    output change, on_off, dev_id, pending, active_cnt
  );

  modport slave (
    output dev_status, stall,
    input  change, on_off, dev_id, pending, active_cnt
  );

endinterface

// File: rtl/device_event_encoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the lowest index at or above ptr (wrapping
// modulo N_DEV) whose request bit is set.
//   req       : request vector, one bit per device
//   ptr       : search start index (always < N_DEV)
//   gnt_valid : some request is set
//   gnt_idx   : granted index (0 when gnt_valid = 0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_DEV-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_idx
);

  int              cand_s;
  logic [ID_W-1:0] cand_idx_s;

  // Scan candidates from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    gnt_valid  = 1'b0;
    gnt_idx    = '0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int k = N_DEV - 1; k >= 0; k--) begin
      cand_s = int'(ptr) + k;
      if (cand_s >= N_DEV) begin
        cand_s = cand_s - N_DEV;
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = ID_W'(cand_s);
      if (req[cand_idx_s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx_s;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/device_event_encoder.sv
// -----------------------------------------------------------------------------
// device_event_encoder
// Detects on/off transitions of N_DEV device status levels, buffers at most
// one net event per device, and issues one change/on_off event per non-stalled
// cycle in round-robin order. active_cnt shadows the downstream counter.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : device_event_encoder_if.master (dev_status, stall in;
//          change, on_off, dev_id, pending, active_cnt out)
// Build option: DEV_SYNC_EN adds a two-flop synchroniser on dev_status
// (two extra cycles of latency).
// -----------------------------------------------------------------------------
module device_event_encoder
  import device_event_encoder_pkg::*;
#(
  parameter int N_DEV = N_DEV_DEFAULT,
  parameter int ID_W  = ID_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  device_event_encoder_if.master bus
);

  logic [N_DEV-1:0] status_s;
  logic [N_DEV-1:0] prev_r;
  logic [N_DEV-1:0] pend_on_r;
  logic [N_DEV-1:0] pend_off_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic             change_r;
  logic             on_off_r;
  logic [ID_W-1:0]  dev_id_r;
  logic             pending_r;
  logic [CNT_W-1:0] active_cnt_r;

  logic [N_DEV-1:0] rise_s;
  logic [N_DEV-1:0] fall_s;
  logic [N_DEV-1:0] req_s;
  logic             gnt_valid_s;
  logic [ID_W-1:0]  gnt_idx_s;
  logic             grant_s;
  logic             gnt_dir_s;
  logic [N_DEV-1:0] gnt_mask_s;
  logic [N_DEV-1:0] on_left_s;
  logic [N_DEV-1:0] off_left_s;
  logic [N_DEV-1:0] pend_on_nxt_s;
  logic [N_DEV-1:0] pend_off_nxt_s;
  logic [ID_W-1:0]  ptr_nxt_s;

`ifdef DEV_SYNC_EN
  logic [N_DEV-1:0] sync1_r;
  logic [N_DEV-1:0] sync2_r;

  // Two-flop synchroniser for asynchronous device levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= bus.dev_status;
      sync2_r <= sync1_r;
    end
  end

  assign status_s = sync2_r;
`else
  assign status_s = bus.dev_status;
`endif

  assign rise_s  = status_s & ~prev_r;
  assign fall_s  = ~status_s & prev_r;
  assign req_s   = pend_on_r | pend_off_r;
  assign grant_s = gnt_valid_s & ~bus.stall;

  rr_arbiter #(
    .N_DEV (N_DEV),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_s),
    .ptr       (rr_ptr_r),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Grant decode, pend-bit update and pointer advance.
  always_comb begin
    gnt_mask_s = '0;
    for (int i = 0; i < N_DEV; i++) begin
      gnt_mask_s[i] = grant_s && (gnt_idx_s == ID_W'(i));
    end
    gnt_dir_s = pend_on_r[gnt_idx_s];
    // Pend bits that survive this cycle's grant; only these can be cancelled,
    // so an opposite edge on the granted device re-arms instead of cancelling.
    on_left_s      = pend_on_r & ~gnt_mask_s;
    off_left_s     = pend_off_r & ~gnt_mask_s;
    pend_on_nxt_s  = (on_left_s & ~fall_s) | (rise_s & ~off_left_s);
    pend_off_nxt_s = (off_left_s & ~rise_s) | (fall_s & ~on_left_s);
    if (gnt_idx_s == ID_W'(N_DEV - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_idx_s + ID_W'(1);
    end
  end

  // State and registered outputs; on_off/dev_id hold when nothing is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r       <= '0;
      pend_on_r    <= '0;
      pend_off_r   <= '0;
      rr_ptr_r     <= '0;
      change_r     <= 1'b0;
      on_off_r     <= 1'b0;
      dev_id_r     <= '0;
      pending_r    <= 1'b0;
      active_cnt_r <= '0;
    end else begin
      prev_r     <= status_s;
      pend_on_r  <= pend_on_nxt_s;
      pend_off_r <= pend_off_nxt_s;
      pending_r  <= |(pend_on_nxt_s | pend_off_nxt_s);
      change_r   <= grant_s;
      if (grant_s) begin
        on_off_r     <= gnt_dir_s;
        dev_id_r     <= gnt_idx_s;
        rr_ptr_r     <= ptr_nxt_s;
        active_cnt_r <= cnt_step(active_cnt_r, gnt_dir_s);
      end
    end
  end

  assign bus.change     = change_r;
  assign bus.on_off     = on_off_r;
  assign bus.dev_id     = dev_id_r;
  assign bus.pending    = pending_r;
  assign bus.active_cnt = active_cnt_r;

endmodule

// File: doc/device_event_encoder.md
# device_event_encoder

Transmit side of the active-device monitoring link. Watches one status level per IoT device, detects on/off transitions, buffers them per device, and serialises them into one `change`/`on_off` event per cycle for the downstream active-device counter. A shadow count lets the bench or system check the counter's value directly.

## Interface

Parameters:
- `N_DEV`, default 8: number of monitored devices, 1..255.
- `ID_W`, default 3: device index width; must satisfy 2^ID_W ≥ N_DEV.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `dev_status`, input, N_DEV: level per device; 1 = on.
- `stall`, input, 1: when 1, no event is issued this cycle and pending events are held.
- `change`, output, 1: one-cycle event strobe to the counter.
- `on_off`, output, 1: event direction, valid when `change`=1; 1 = increment, 0 = decrement.
- `dev_id`, output, ID_W: index of the device the event belongs to.
- `pending`, output, 1: at least one event is buffered.
- `active_cnt`, output, 8: count of devices reported on so far; equals the downstream counter after every event.

## Operation

- State:
  - `prev`, N_DEV bits: last sampled status.
  - `pend_on` and `pend_off`, N_DEV bits each: buffered events.
  - `rr_ptr`, ID_W bits: round-robin pointer.
  - Output registers.
- Edge detect, per device i, each cycle:
  - rise = `dev_status[i]` & ~`prev[i]`.
  - fall = ~`dev_status[i]` & `prev[i]`.
  - `prev` is updated with `dev_status` every cycle.
- Buffering, per device; at most one of `pend_on[i]` / `pend_off[i]` is set at any time:
  - Rise with `pend_off[i]` set and not granted this cycle: clear `pend_off[i]` (cancel). Otherwise set `pend_on[i]`.
  - Fall is symmetric: cancel a pending `pend_on[i]`, otherwise set `pend_off[i]`.
  - The buffer never overflows, because each device holds at most one net event.
- Arbitration, when `stall`=0 and any pend bit is set:
  - Grant the lowest index j ≥ `rr_ptr` (wrapping modulo N_DEV) with `pend_on[j]` | `pend_off[j]`.
  - Registered outputs: `change`=1, `on_off`=`pend_on[j]`, `dev_id`=j.
  - Clear the granted pend bit.
  - `rr_ptr` ← j+1, wrapping N_DEV-1 → 0.
- Grant and a new opposite edge on the same device in the same cycle:
  - The grant completes.
  - The new edge sets the opposite pend bit; no cancellation.
- No grant (stall or nothing pending): `change`=0; `on_off` and `dev_id` hold their last values.
- `active_cnt`:
  - +1 on an issued on event, −1 on an issued off event.
  - Updated in the same edge as `change`.
  - Never wraps in legal operation, since the count stays within 0..N_DEV.
- `pending`: the OR of all pend bits after the edge.

## Timing

- Reset (`rst`=0, asynchronous) sets all registers to 0. This includes `prev`, so devices already on at reset release produce rise events.
- Outputs during reset: `change`=0, `on_off`=0, `dev_id`=0, `pending`=0, `active_cnt`=0.
- Reset mid-operation discards all buffered events.
- Latency, from the edge that first samples the new status to `change` high:
  - The pend bit is set at edge E0.
  - `change` is registered at E1, so it is high in the cycle after E1.
- Throughput: one event per non-stalled cycle.
- Worst-case drain of N_DEV simultaneous edges: N_DEV cycles.
- `stall` is sampled at the same edge that would register the grant.

## Configuration

- `DEV_SYNC_EN` defined:
  - `dev_status` passes through a two-flop synchroniser per bit before edge detection, reset to 0.
  - Latency grows by 2 cycles.
- `DEV_SYNC_EN` undefined: `dev_status` must already be synchronous to `clk` and is used directly.

## Structure

- A shared package, also used by the monitor, holds:
  - Counter width constant `CNT_W` = 8.
  - Direction constants `EVT_ON` = 1, `EVT_OFF` = 0.
  - Default `N_DEV`.
- Sub-module `rr_arbiter`:
  - Inputs: N_DEV-bit request vector, pointer.
  - Outputs: grant valid, grant index.
  - Purely combinational; instantiated once.

## Test plan

- Reset: hold `rst`=0 with `dev_status`=8'hFF → all outputs 0. Release → 8 events, dev_id 0..7, all `on_off`=1, one per cycle; `active_cnt` ends at 8.
- Single device 3 rises → `change` high for exactly 1 cycle after 2 edges, `dev_id`=3, `on_off`=1, `active_cnt`=1; `pending` falls the same edge.
- Pulse cancellation:
  - Set `stall`=1.
  - Device 5 goes on, then off 2 cycles later.
  - Release `stall` → no event issued, `active_cnt` unchanged.
- Round-robin and wrap:
  - `rr_ptr`=6 (after a device-5 event), devices 1, 6, 7 rise together.
  - → grant order 6, 7, 1.
- Stall hold: 4 pending events with `stall`=1 for 10 cycles → `change` stays 0 and `pending`=1; after release, exactly 4 strobes, back-to-back.
- Golden check: random toggles across 8 devices for 1000 cycles, feeding a model counter (+1/−1 on `change`) → `active_cnt` matches the model every cycle. After draining, it equals the popcount of `dev_status`.
